// File: rtl/net_bus_tx_fanout_if.sv
// NetBus TX fan-out bus bundle: upstream word handshake, per-channel downstream links and status.
// The master side belongs to the source/sink environment; the fan-out itself uses the slave side.
interface net_bus_tx_fanout_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CHANNELS   = 4
);
  localparam int W = DATA_WIDTH * 9 + 14;

  logic                  mode;
  logic [CHANNELS-1:0]   ch_en;
  logic [W-1:0]          data;
  logic                  valid;
  logic                  ready;
  logic [CHANNELS-1:0]   wclk;
  logic [CHANNELS*W-1:0] wdata;
  logic [CHANNELS-1:0]   wvalid;
  logic [CHANNELS-1:0]   wready;
  logic                  drop;
  logic [15:0]           word_cnt;
  logic [15:0]           drop_cnt;

  modport master (
    output mode, ch_en, data, valid, wready,
    input  ready, wclk, wdata, wvalid, drop, word_cnt, drop_cnt
  );

  modport slave (
    input  mode, ch_en, data, valid, wready,
    output ready, wclk, wdata, wvalid, drop, word_cnt, drop_cnt
  );
endinterface

// File: rtl/net_bus_tx_fanout.sv
// N-channel NetBus TX fan-out: one held word is broadcast to every enabled channel or dispatched round-robin.
// Define NETBUS_TX_STATS_EN to build the retired/dropped word counters; otherwise they read as zero.
module net_bus_tx_fanout #(
  parameter int DATA_WIDTH = 4,
  parameter int CHANNELS   = 4
) (
  input logic                    clk_i,
  input logic                    resetn_i,
  net_bus_tx_fanout_if.slave     bus
);
  localparam int W  = DATA_WIDTH * 9 + 14;
  localparam int PW = $clog2(CHANNELS);

  logic                hold_valid_q, hold_valid_d;
  logic [W-1:0]        hold_data_q, hold_data_d;
  logic                hold_mode_q, hold_mode_d;
  logic [CHANNELS-1:0] hold_en_q, hold_en_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       last_q, last_d;

  logic [CHANNELS-1:0] rr_onehot, wvalid, xfer;
  logic                drop_cond, retire, load, ready;
  logic [PW-1:0]       last_eff, next_ptr, cand;
  logic                found;

  always_comb begin
    rr_onehot           = '0;
    rr_onehot[rr_ptr_q] = 1'b1;
  end

  assign drop_cond = hold_valid_q & (hold_en_q == '0);
  assign wvalid    = {CHANNELS{resetn_i & hold_valid_q & ~drop_cond}}
                   & (hold_mode_q ? rr_onehot : (hold_en_q & ~done_q));
  assign xfer      = wvalid & bus.wready;
  assign retire    = hold_valid_q & ~drop_cond
                   & (hold_mode_q ? |(rr_onehot & xfer) : &(done_q | xfer | ~hold_en_q));
  assign ready     = resetn_i & (~hold_valid_q | retire | drop_cond);
  assign load      = bus.valid & ready;

  // A dispatch retire in the same cycle as a load moves the search origin to the channel just served.
  assign last_eff = (retire & hold_mode_q) ? rr_ptr_q : last_q;

  always_comb begin
    next_ptr = rr_ptr_q;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = PW'((int'(last_eff) + k) % CHANNELS);
      if (!found && bus.ch_en[cand]) begin
        next_ptr = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_mode_d  = hold_mode_q;
    hold_en_d    = hold_en_q;
    done_d       = done_q;
    rr_ptr_d     = rr_ptr_q;
    last_d       = last_q;
    if (retire | drop_cond) hold_valid_d = 1'b0;
    if (hold_valid_q & ~hold_mode_q) done_d = done_q | xfer;
    if (retire & hold_mode_q) last_d = rr_ptr_q;
    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = bus.data;
      hold_mode_d  = bus.mode;
      hold_en_d    = bus.ch_en;
      done_d       = '0;
      if (bus.mode & found) rr_ptr_d = next_ptr;
    end
  end

  // Search origin starts at the last channel so the first dispatched word goes to channel 0.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      hold_valid_q <= 1'b0;
      done_q       <= '0;
      rr_ptr_q     <= '0;
      last_q       <= PW'(CHANNELS - 1);
    end else begin
      hold_valid_q <= hold_valid_d;
      done_q       <= done_d;
      rr_ptr_q     <= rr_ptr_d;
      last_q       <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    hold_data_q <= hold_data_d;
    hold_mode_q <= hold_mode_d;
    hold_en_q   <= hold_en_d;
  end

  assign bus.ready  = ready;
  assign bus.wvalid = wvalid;
  assign bus.wdata  = {CHANNELS{hold_data_q}};
  assign bus.wclk   = {CHANNELS{clk_i}};
  assign bus.drop   = resetn_i & drop_cond;

`ifdef NETBUS_TX_STATS_EN
  logic [15:0] word_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (retire)    word_cnt_q <= word_cnt_q + 16'd1;
      if (drop_cond) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.word_cnt = word_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.word_cnt = '0;
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_net_bus_tx_fanout.sv
// Bench for net_bus_tx_fanout: directed phases plus a random phase, checked against a set-of-owed-channels model.
// Counter expectations follow NETBUS_TX_STATS_EN.
module tb_net_bus_tx_fanout;
  localparam int DW = 4;
  localparam int CH = 4;
  localparam int W  = DW * 9 + 14;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  net_bus_tx_fanout_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  net_bus_tx_fanout #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: the held word, the channels still owed it, and the round-robin origin.
  logic          mHeld    = 1'b0;
  logic          mDrop    = 1'b0;
  logic          mMode    = 1'b0;
  logic [CH-1:0] mPending = '0;
  logic [W-1:0]  mData    = '0;
  int            mDest    = 0;
  int            mLast    = CH - 1;
  int            mWordCnt = 0;
  int            mDropCnt = 0;
  bit            mLoaded  = 1'b0;
  bit            expReadyNow = 1'b0;

  logic [W-1:0] txQ[$];
  int           servedOrder[$];
  int           expOrder[6] = '{0, 1, 3, 0, 1, 3};

  function automatic logic [W-1:0] randWord();
    return W'({$urandom, $urandom});
  endfunction

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [CH-1:0] en, input logic [CH-1:0] rdy);
    bus.mode   = m;
    bus.ch_en  = en;
    bus.wready = rdy;
  endtask

  task automatic checkOutput();
    logic [CH-1:0] expW;
    logic          expR, expD;
    logic [15:0]   expWc, expDc;
    expW = resetn ? mPending : '0;
    expR = resetn && ((mPending & ~bus.wready) == '0);
    expD = resetn && mDrop;
`ifdef NETBUS_TX_STATS_EN
    expWc = 16'(mWordCnt);
    expDc = 16'(mDropCnt);
`else
    expWc = '0;
    expDc = '0;
`endif
    expReadyNow = expR;
    compare("wvalid", 64'(bus.wvalid), 64'(expW));
    compare("ready", 64'(bus.ready), 64'(expR));
    compare("drop", 64'(bus.drop), 64'(expD));
    compare("word_cnt", 64'(bus.word_cnt), 64'(expWc));
    compare("drop_cnt", 64'(bus.drop_cnt), 64'(expDc));
    for (int i = 0; i < CH; i++)
      if (expW[i]) compare($sformatf("wdata[%0d]", i), 64'(bus.wdata[i*W +: W]), 64'(mData));
  endtask

  task automatic updateModel();
    int c;
    mLoaded = 1'b0;
    if (!resetn) begin
      mHeld = 1'b0; mDrop = 1'b0; mPending = '0; mLast = CH - 1;
      mWordCnt = 0; mDropCnt = 0;
    end else begin
      if (mDrop) begin
        mDropCnt++; mDrop = 1'b0; mHeld = 1'b0;
      end else if (mHeld) begin
        mPending = mPending & ~bus.wready;
        if (mPending == '0) begin
          mWordCnt++;
          mHeld = 1'b0;
          if (mMode) begin
            mLast = mDest;
            servedOrder.push_back(mDest);
          end
        end
      end
      if (bus.valid && expReadyNow) begin
        mLoaded = 1'b1; mHeld = 1'b1; mData = bus.data; mMode = bus.mode;
        if (bus.ch_en == '0) begin
          mDrop = 1'b1; mPending = '0;
        end else if (bus.mode) begin
          for (int k = 1; k <= CH; k++) begin
            c = (mLast + k) % CH;
            if (bus.ch_en[c]) begin
              mDest = c;
              break;
            end
          end
          mPending = CH'(1) << mDest;
        end else begin
          mPending = bus.ch_en;
        end
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    updateModel();
  endtask

  task automatic queueCycle();
    bus.valid = (txQ.size() > 0);
    if (txQ.size() > 0) bus.data = txQ[0];
    stepCycle();
    if (mLoaded) void'(txQ.pop_front());
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((txQ.size() > 0 || mHeld) && n < maxCycles) begin
      queueCycle();
      n++;
    end
    compare("drain_timeout", 64'(txQ.size() > 0 || mHeld), 64'(0));
  endtask

  task automatic pulseReset(input int n);
    bus.valid = 1'b0;
    resetn = 1'b0;
    repeat (n) stepCycle();
    resetn = 1'b1;
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.data  = '0;
    applyStimulus(1'b0, '0, '0);
    pulseReset(2);

    $display("[TB] broadcast back-to-back");
    applyStimulus(1'b0, 4'hF, 4'hF);
    txQ.push_back(W'(1)); txQ.push_back(W'(2)); txQ.push_back(W'(3));
    drain(20);
`ifdef NETBUS_TX_STATS_EN
    compare("bcast_word_cnt", 64'(bus.word_cnt), 64'(3));
`else
    compare("bcast_word_cnt", 64'(bus.word_cnt), 64'(0));
`endif

    $display("[TB] broadcast slow channel");
    applyStimulus(1'b0, 4'hF, 4'b1011);
    txQ.push_back(randWord()); txQ.push_back(randWord());
    repeat (5) queueCycle();
    applyStimulus(1'b0, 4'hF, 4'hF);
    drain(20);

    $display("[TB] dispatch round-robin");
    pulseReset(1);
    servedOrder.delete();
    applyStimulus(1'b1, 4'b1011, 4'hF);
    repeat (6) txQ.push_back(randWord());
    drain(30);
    compare("dispatch_count", 64'(servedOrder.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < servedOrder.size()) compare("dispatch_order", 64'(servedOrder[i]), 64'(expOrder[i]));

    $display("[TB] empty mask");
    applyStimulus(1'b0, 4'h0, 4'hF);
    txQ.push_back(randWord());
    queueCycle();
    applyStimulus(1'b0, 4'hF, 4'hF);
    txQ.push_back(randWord());
    drain(20);
`ifdef NETBUS_TX_STATS_EN
    compare("empty_drop_cnt", 64'(bus.drop_cnt), 64'(1));
`else
    compare("empty_drop_cnt", 64'(bus.drop_cnt), 64'(0));
`endif

    $display("[TB] reset mid-delivery");
    applyStimulus(1'b0, 4'hF, 4'h0);
    txQ.push_back(randWord());
    repeat (3) queueCycle();
    pulseReset(1);
    applyStimulus(1'b0, 4'hF, 4'hF);
    repeat (3) queueCycle();

    $display("[TB] config sampling");
    applyStimulus(1'b0, 4'hF, 4'h0);
    txQ.push_back(randWord());
    repeat (2) queueCycle();
    applyStimulus(1'b1, 4'b0101, 4'h0);
    repeat (2) queueCycle();
    applyStimulus(1'b1, 4'b0101, 4'hF);
    repeat (3) txQ.push_back(randWord());
    drain(30);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 39) != 0);
      applyStimulus(1'($urandom), CH'($urandom), CH'($urandom));
      bus.valid = ($urandom_range(0, 9) < 7);
      bus.data  = randWord();
      stepCycle();
    end
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
